// File: rtl/icache_set_assoc_fetch.sv
// rtl/icache_set_assoc_fetch.sv - N-way set-associative instruction cache with round-robin refill
//
// Purpose: accepts line fetch requests, answers hits one cycle after acceptance,
// refills misses from the bus access unit and supports full invalidation and flush.
// Optional build macro: ICACHE_PERF_COUNTER_EN adds perf_hit_count / perf_miss_count.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready/req_paddr fetch request handshake and physical address
//   flush                         kills the lookup being resolved this cycle
//   resp_valid/resp_line/resp_paddr  line response and its line-aligned address
//   mem_read_req/mem_addr         refill request and line address to the bus unit
//   mem_read_grant/mem_read_value refill completion and data
//   inval_req/inval_done          full invalidation request and completion pulse
module icache_set_assoc_fetch #(
  parameter int LINE_WIDTH  = 128,
  parameter int INDEX_WIDTH = 6,
  parameter int WAY_COUNT   = 2,
  parameter int PADDR_WIDTH = 34,
  localparam int OFFSET_W   = $clog2(LINE_WIDTH / 8),
  localparam int TAG_W      = PADDR_WIDTH - INDEX_WIDTH - OFFSET_W,
  localparam int MADDR_W    = PADDR_WIDTH - OFFSET_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PADDR_WIDTH-1:0] req_paddr,
  input  logic                   flush,
  output logic                   resp_valid,
  output logic [LINE_WIDTH-1:0]  resp_line,
  output logic [PADDR_WIDTH-1:0] resp_paddr,
  output logic                   mem_read_req,
  output logic [MADDR_W-1:0]     mem_addr,
  input  logic                   mem_read_grant,
  input  logic [LINE_WIDTH-1:0]  mem_read_value,
  input  logic                   inval_req,
  output logic                   inval_done
`ifdef ICACHE_PERF_COUNTER_EN
  ,
  output logic [31:0]            perf_hit_count,
  output logic [31:0]            perf_miss_count
`endif
);

  localparam int SETS  = 2 ** INDEX_WIDTH;
  localparam int PTR_W = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_INVAL   = 2'd0,
    ST_DEFAULT = 2'd1,
    ST_REFILL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [INDEX_WIDTH-1:0]            walk_q;
  logic                              pend_valid;
  logic [MADDR_W-1:0]                pend_line;
  logic                              inval_lat;
  logic                              inval_q;
  logic [SETS-1:0][PTR_W-1:0]        rr_q;

  logic [INDEX_WIDTH-1:0]            req_index;
  logic [INDEX_WIDTH-1:0]            pend_index;
  logic [TAG_W-1:0]                  pend_tag;
  logic [PTR_W-1:0]                  victim;
  logic [PTR_W-1:0]                  victim_next;
  logic                              accept;
  logic                              lookup;
  logic                              miss;
  logic                              hit_any;
  logic                              fill_en;
  logic                              inval_rise;
  logic [WAY_COUNT-1:0]              hit_vec;
  logic [WAY_COUNT-1:0][LINE_WIDTH-1:0] way_line;
  logic [LINE_WIDTH-1:0]             hit_line;
  logic                              unused_paddr_bits;

  assign req_index  = req_paddr[INDEX_WIDTH+OFFSET_W-1:OFFSET_W];
  assign pend_index = pend_line[INDEX_WIDTH-1:0];
  assign pend_tag   = pend_line[MADDR_W-1:INDEX_WIDTH];
  assign unused_paddr_bits = &{1'b0, req_paddr[OFFSET_W-1:0]};

  assign accept     = req_valid && req_ready;
  // A flushed lookup is treated as if it never existed: no response, no refill.
  assign lookup     = (state_q == ST_DEFAULT) && pend_valid && !flush;
  assign hit_any    = |hit_vec;
  assign miss       = lookup && !hit_any;
  assign fill_en    = (state_q == ST_REFILL) && mem_read_grant;
  // Edge-detect so a level-held request triggers one walk instead of looping.
  assign inval_rise = inval_req && !inval_q;

  assign victim      = (WAY_COUNT == 1) ? '0 : rr_q[pend_index];
  assign victim_next = (victim == PTR_W'(WAY_COUNT - 1)) ? '0 : victim + 1'b1;

  assign mem_addr   = pend_line;
  assign resp_paddr = {pend_line, {OFFSET_W{1'b0}}};

  for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
    logic [TAG_W:0]        tag_ram [SETS];
    logic [LINE_WIDTH-1:0] data_ram [SETS];
    logic [TAG_W:0]        rd_tag;
    logic [LINE_WIDTH-1:0] rd_data;
    logic                  fill_this;

    assign fill_this = fill_en && (victim == PTR_W'(w));

    always_ff @(posedge clk) begin
      if (state_q == ST_INVAL) begin
        tag_ram[walk_q] <= '0;
      end else if (fill_this) begin
        tag_ram[pend_index] <= {1'b1, pend_tag};
      end
      if (fill_this) begin
        data_ram[pend_index] <= mem_read_value;
      end
      if (accept) begin
        rd_tag  <= tag_ram[req_index];
        rd_data <= data_ram[req_index];
      end
    end

    assign hit_vec[w]  = rd_tag[TAG_W] && (rd_tag[TAG_W-1:0] == pend_tag);
    assign way_line[w] = hit_vec[w] ? rd_data : '0;
  end

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      hit_line = hit_line | way_line[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INVAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_line    = hit_line;
    mem_read_req = 1'b0;
    inval_done   = 1'b0;
    case (state_q)
      ST_INVAL: begin
        if (!inval_rise && (walk_q == {INDEX_WIDTH{1'b1}})) begin
          inval_done = 1'b1;
          state_d    = ST_DEFAULT;
        end
      end
      ST_DEFAULT: begin
        req_ready  = !inval_lat && !miss;
        resp_valid = lookup && hit_any;
        if (miss) begin
          state_d = ST_REFILL;
        end else if (inval_lat && !pend_valid) begin
          state_d = ST_INVAL;
        end
      end
      ST_REFILL: begin
        mem_read_req = 1'b1;
        if (mem_read_grant) begin
          resp_valid = pend_valid && !flush;
          resp_line  = mem_read_value;
          state_d    = (inval_lat || inval_rise) ? ST_INVAL : ST_DEFAULT;
        end
      end
      default: state_d = ST_INVAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_q     <= '0;
      pend_valid <= 1'b0;
      pend_line  <= '0;
      inval_lat  <= 1'b0;
      inval_q    <= 1'b0;
      rr_q       <= '0;
    end else begin
      inval_q <= inval_req;
      // Walk counter sits at 0 outside the walk so every walk starts at set 0.
      walk_q  <= (state_q == ST_INVAL && !inval_rise) ? walk_q + 1'b1 : '0;

      if (state_d == ST_INVAL) begin
        inval_lat <= 1'b0;
      end else if (inval_rise) begin
        inval_lat <= 1'b1;
      end

      case (state_q)
        ST_DEFAULT: begin
          if (accept) begin
            pend_valid <= 1'b1;
            pend_line  <= req_paddr[PADDR_WIDTH-1:OFFSET_W];
          end else if (!miss) begin
            pend_valid <= 1'b0;
          end
        end
        // During refill pend_valid means "response still wanted".
        ST_REFILL: if (flush || mem_read_grant) pend_valid <= 1'b0;
        default:   pend_valid <= 1'b0;
      endcase

      if (state_q == ST_INVAL) begin
        rr_q[walk_q] <= '0;
      end else if (fill_en) begin
        rr_q[pend_index] <= victim_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_DEFAULT && pend_valid) begin
      assert ($onehot0(hit_vec));
    end
  end

`ifdef ICACHE_PERF_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_count  <= '0;
      perf_miss_count <= '0;
    end else begin
      if (lookup && hit_any) perf_hit_count  <= perf_hit_count + 32'd1;
      if (miss)              perf_miss_count <= perf_miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_set_assoc_fetch.sv
// tb/tb_icache_set_assoc_fetch.sv - directed vector bench for icache_set_assoc_fetch
module tb_icache_set_assoc_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [33:0]  req_paddr;
  logic         flush;
  logic         resp_valid;
  logic [127:0] resp_line;
  logic [33:0]  resp_paddr;
  logic         mem_read_req;
  logic [29:0]  mem_addr;
  logic         mem_read_grant;
  logic [127:0] mem_read_value;
  logic         inval_req;
  logic         inval_done;

  int passed = 0;
  int total  = 0;

  icache_set_assoc_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_paddr      (req_paddr),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_line      (resp_line),
    .resp_paddr     (resp_paddr),
    .mem_read_req   (mem_read_req),
    .mem_addr       (mem_addr),
    .mem_read_grant (mem_read_grant),
    .mem_read_value (mem_read_value),
    .inval_req      (inval_req),
    .inval_done     (inval_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0]  paddr;
    logic         hit;
    logic [127:0] line;
  } vec_t;

  vec_t tbl [12];

  localparam logic [127:0] L1000  = 128'h00001000_11111111_22222222_33333333;
  localparam logic [127:0] L1010  = 128'h00001010_44444444_55555555_66666666;
  localparam logic [127:0] L0000  = 128'h00000000_77777777_88888888_99999999;
  localparam logic [127:0] L0400  = 128'h00000400_AAAAAAAA_BBBBBBBB_CCCCCCCC;
  localparam logic [127:0] L0800  = 128'h00000800_DDDDDDDD_EEEEEEEE_FFFFFFFF;
  localparam logic [127:0] L0000B = 128'h0000000B_0BADF00D_12345678_9ABCDEF0;
  localparam logic [127:0] L1000B = 128'h1000000B_CAFEBABE_DEADBEEF_01020304;
  localparam logic [127:0] LHIGH  = 128'hFFFFFFFF_5A5A5A5A_A5A5A5A5_FFFF0000;
  localparam logic [127:0] L2000  = 128'h00002000_13579BDF_2468ACE0_0F0F0F0F;
  localparam logic [127:0] L3000  = 128'h00003000_F0F0F0F0_0E0E0E0E_D0D0D0D0;
  localparam logic [127:0] L1010B = 128'h1010000B_76543210_FEDCBA98_11223344;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic walk_check(input string nm);
    int cnt, done_at, dones;
    cnt = 0; done_at = -1; dones = 0;
    @(negedge clk);
    while (!req_ready && cnt < 200) begin
      if (inval_done) begin done_at = cnt; dones++; end
      cnt++;
      @(negedge clk);
    end
    chk({nm, "_ready_low_cycles"}, cnt, 64);
    chk({nm, "_done_cycle"}, done_at, 63);
    chk({nm, "_done_pulses"}, dones, 1);
    chk({nm, "_done_after"}, inval_done, 1'b0);
  endtask

  // Called right after the miss-cycle sample; fl/iv select the waiting cycle
  // that pulses flush / inval_req (-1 for none).
  task automatic do_refill(input logic [33:0] pa, input logic [127:0] val,
                           input int delay, input int fl, input int iv);
    for (int c = 0; c < delay; c++) begin
      @(posedge clk); #1;
      flush     = (c == fl);
      inval_req = (c == iv);
      @(negedge clk);
      chk("refill_req", mem_read_req, 1'b1);
      chk("refill_addr", mem_addr, pa >> 4);
    end
    @(posedge clk); #1;
    flush = 1'b0; inval_req = 1'b0;
    mem_read_grant = 1'b1; mem_read_value = val;
    @(negedge clk);
    chk("grant_resp_valid", resp_valid, (fl < 0));
    if (fl < 0) begin
      chk("grant_resp_line", resp_line, val);
      chk("grant_resp_paddr", resp_paddr, pa & ~34'hF);
    end
    @(posedge clk); #1;
    mem_read_grant = 1'b0; mem_read_value = '0;
  endtask

  task automatic fetch(input logic [33:0] pa, input logic hit, input logic [127:0] val,
                       input int fl, input int iv);
    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = pa;
    @(negedge clk);
    chk("fetch_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("lookup_resp_valid", resp_valid, hit);
    chk("lookup_mem_req", mem_read_req, 1'b0);
    if (hit) begin
      chk("hit_line", resp_line, val);
      chk("hit_paddr", resp_paddr, pa & ~34'hF);
    end else begin
      chk("miss_ready", req_ready, 1'b0);
      do_refill(pa, val, 2, fl, iv);
    end
  endtask

  initial begin
    tbl[0]  = '{34'h0_0000_1000, 1'b1, L1000};
    tbl[1]  = '{34'h0_0000_1010, 1'b0, L1010};
    tbl[2]  = '{34'h0_0000_0000, 1'b0, L0000};
    tbl[3]  = '{34'h0_0000_0400, 1'b0, L0400};
    tbl[4]  = '{34'h0_0000_0800, 1'b0, L0800};
    tbl[5]  = '{34'h0_0000_0400, 1'b1, L0400};
    tbl[6]  = '{34'h0_0000_0000, 1'b0, L0000B};
    tbl[7]  = '{34'h0_0000_0808, 1'b1, L0800};
    tbl[8]  = '{34'h0_0000_1010, 1'b1, L1010};
    tbl[9]  = '{34'h0_0000_1000, 1'b0, L1000B};
    tbl[10] = '{34'h3_FFFF_FFF0, 1'b0, LHIGH};
    tbl[11] = '{34'h3_FFFF_FFFC, 1'b1, LHIGH};

    rst = 1'b1; req_valid = 1'b1; req_paddr = 34'h0_0000_1000;
    flush = 1'b0; mem_read_grant = 1'b0; mem_read_value = '0; inval_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_read_req", mem_read_req, 1'b0);
    chk("rst_inval_done", inval_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    walk_check("reset_walk");

    // Request held through the walk is accepted now: cold miss of 0x1000.
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("cold_resp_valid", resp_valid, 1'b0);
    chk("cold_ready", req_ready, 1'b0);
    do_refill(34'h0_0000_1000, L1000, 3, -1, -1);

    for (int i = 0; i < 12; i++) begin
      fetch(tbl[i].paddr, tbl[i].hit, tbl[i].line, -1, -1);
    end

    // Back-to-back hits with req_valid held.
    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = 34'h0_0000_1000;
    @(negedge clk);
    chk("b2b_ready0", req_ready, 1'b1);
    @(posedge clk); #1;
    req_paddr = 34'h0_0000_1010;
    @(negedge clk);
    chk("b2b_valid0", resp_valid, 1'b1);
    chk("b2b_line0", resp_line, L1000B);
    chk("b2b_paddr0", resp_paddr, 34'h0_0000_1000);
    chk("b2b_ready1", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", resp_valid, 1'b1);
    chk("b2b_line1", resp_line, L1010);
    chk("b2b_paddr1", resp_paddr, 34'h0_0000_1010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle", resp_valid, 1'b0);

    // Flush kills a hit; redirect request presented with flush is accepted.
    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = 34'h0_0000_1010;
    @(posedge clk); #1;
    flush = 1'b1; req_paddr = 34'h0_0000_1000;
    @(negedge clk);
    chk("flush_hit_killed", resp_valid, 1'b0);
    chk("flush_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("redirect_valid", resp_valid, 1'b1);
    chk("redirect_line", resp_line, L1000B);
    chk("redirect_paddr", resp_paddr, 34'h0_0000_1000);

    // Flush during refill: no response, but the line is installed.
    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = 34'h0_0000_2000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flmiss_ready", req_ready, 1'b0);
    do_refill(34'h0_0000_2000, L2000, 6, 0, -1);
    fetch(34'h0_0000_2000, 1'b1, L2000, -1, -1);

    // Invalidate requested mid-refill: refill completes, then full walk.
    @(posedge clk); #1;
    req_valid = 1'b1; req_paddr = 34'h0_0000_3000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("invmiss_ready", req_ready, 1'b0);
    do_refill(34'h0_0000_3000, L3000, 3, -1, 1);
    walk_check("inval_walk");
    fetch(34'h0_0000_1010, 1'b0, L1010B, -1, -1);
    fetch(34'h0_0000_1010, 1'b1, L1010B, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
